// File: rtl/m_spi_slave_if.sv
// SPI pin bundle between an external master and m_spi_slave.
interface m_spi_slave_if;
  logic SCLK_SLAVE;
  logic SS_N_SLAVE;
  logic MOSI_SLAVE;
  logic MISO_SLAVE;

  modport master (output SCLK_SLAVE, output SS_N_SLAVE, output MOSI_SLAVE, input MISO_SLAVE);
  modport slave  (input SCLK_SLAVE, input SS_N_SLAVE, input MOSI_SLAVE, output MISO_SLAVE);
endinterface

// File: rtl/m_spi_slave.sv
// SPI mode-0 slave oversampled by I_CLK: synchronized pins, RX word assembly,
// TX holding register with idle-word fallback, frame and underrun reporting.
module m_spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  m_spi_slave_if.slave          spi,
  input  logic                  I_TX_WE,
  input  logic [DATA_WIDTH-1:0] I_TX_DATA,
  output logic                  O_TX_READY,
  output logic [DATA_WIDTH-1:0] O_RX_DATA,
  output logic                  O_RX_VALID,
  output logic [5:0]            O_BYTE_CNT,
  output logic                  O_BUSY,
  output logic                  O_TX_UNDERRUN,
  output logic                  O_FRAME_ERR
);

  localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_sync_q, ss_sync_q;
  logic [1:0]              mosi_sync_q;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [5:0]              byte_cnt_q, byte_cnt_d;
  logic                    word_done_q, word_done_d;
  logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    underrun_q, underrun_d;
  logic                    ferr_q, ferr_d;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic start, stop, rise_act, fall_act, load;
  logic busy, miso;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
    return {v[DATA_WIDTH-2:0], b};
  endfunction

  // Stage 2 of each synchronizer is the usable sample, stage 3 its one-cycle-old copy.
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
  assign mosi_s    =  mosi_sync_q[1];

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ACTIVE);
    miso = busy & tx_sh_q[DATA_WIDTH-1];
  end

  // A slave-select release outranks any SCLK edge seen in the same cycle.
  assign start    = (state_q == IDLE) & ss_fall;
  assign stop     = (state_q == ACTIVE) & ss_rise;
  assign rise_act = (state_q == ACTIVE) & ~ss_rise & sclk_rise;
  assign fall_act = (state_q == ACTIVE) & ~ss_rise & sclk_fall;
  assign load     = start | (fall_act & word_done_q);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_done_d = word_done_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    ferr_d      = 1'b0;

    if (start) begin
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      word_done_d = 1'b0;
    end

    if (stop) begin
      bit_cnt_d   = '0;
      word_done_d = 1'b0;
      ferr_d      = (bit_cnt_q != '0);
    end

    if (rise_act) begin
      rx_sh_d = shift_in(rx_sh_q, mosi_s);
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d   = '0;
        word_done_d = 1'b1;
        rx_data_d   = shift_in(rx_sh_q, mosi_s);
        rx_valid_d  = 1'b1;
        byte_cnt_d  = byte_cnt_q + 6'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    if (fall_act) begin
      if (word_done_q) word_done_d = 1'b0;
      else             tx_sh_d     = tx_sh_q << 1;
    end

    if (load) begin
      tx_sh_d    = hold_full_q ? hold_q : IDLE_WORD;
      underrun_d = ~hold_full_q;
    end

    // An empty register still accepts a write in the cycle it underruns.
    if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (I_TX_WE && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = I_TX_DATA;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      word_done_q <= 1'b0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.SCLK_SLAVE};
      ss_sync_q   <= {ss_sync_q[1:0], spi.SS_N_SLAVE};
      mosi_sync_q <= {mosi_sync_q[0], spi.MOSI_SLAVE};
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_done_q <= word_done_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign spi.MISO_SLAVE = miso;
  assign O_BUSY         = busy;
  assign O_TX_READY     = ~hold_full_q;
  assign O_RX_DATA      = rx_data_q;
  assign O_RX_VALID     = rx_valid_q;
  assign O_BYTE_CNT     = byte_cnt_q;
  assign O_TX_UNDERRUN  = underrun_q;
  assign O_FRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_m_spi_slave.sv
// Directed bench for m_spi_slave: a mode-0 master model drives frames while a
// monitor pops expected RX words and MISO words from scoreboard queues.
module tb_m_spi_slave;
  localparam int HALF = 8;

  logic       I_CLK = 1'b0;
  logic       I_RESETN = 1'b0;
  logic       I_TX_WE = 1'b0;
  logic [7:0] I_TX_DATA = 8'h00;
  logic       O_TX_READY;
  logic [7:0] O_RX_DATA;
  logic       O_RX_VALID;
  logic [5:0] O_BYTE_CNT;
  logic       O_BUSY;
  logic       O_TX_UNDERRUN;
  logic       O_FRAME_ERR;

  m_spi_slave_if sif ();

  m_spi_slave #(.DATA_WIDTH(8), .IDLE_WORD(8'h00)) dut (
    .I_CLK        (I_CLK),
    .I_RESETN     (I_RESETN),
    .spi          (sif.slave),
    .I_TX_WE      (I_TX_WE),
    .I_TX_DATA    (I_TX_DATA),
    .O_TX_READY   (O_TX_READY),
    .O_RX_DATA    (O_RX_DATA),
    .O_RX_VALID   (O_RX_VALID),
    .O_BYTE_CNT   (O_BYTE_CNT),
    .O_BUSY       (O_BUSY),
    .O_TX_UNDERRUN(O_TX_UNDERRUN),
    .O_FRAME_ERR  (O_FRAME_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  int errors = 0;
  int checks = 0;
  int n_valid = 0, n_under = 0, n_ferr = 0;
  int v0, u0, f0;
  logic [7:0] rxq[$];
  logic [5:0] cntq[$];
  logic [7:0] misoq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  task automatic monitor();
    logic       sclk_prev = 1'b0;
    logic [7:0] msh = 8'h00;
    int         mbits = 0;
    forever begin
      @(negedge I_CLK);
      if (O_RX_VALID) begin
        n_valid++;
        if (rxq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no word", O_RX_DATA);
        end else begin
          chk("rx_data", 32'(O_RX_DATA), 32'(rxq.pop_front()));
          chk("rx_byte_cnt", 32'(O_BYTE_CNT), 32'(cntq.pop_front()));
        end
      end
      if (O_TX_UNDERRUN) n_under++;
      if (O_FRAME_ERR)   n_ferr++;
      if (sif.SS_N_SLAVE) begin
        mbits = 0;
      end else if (sif.SCLK_SLAVE && !sclk_prev) begin
        msh = {msh[6:0], sif.MISO_SLAVE};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (misoq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got 0x%0h, expected no word", msh);
          end else begin
            chk("miso_word", 32'(msh), 32'(misoq.pop_front()));
          end
        end
      end
      sclk_prev = sif.SCLK_SLAVE;
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    I_TX_WE = 1'b1;
    I_TX_DATA = d;
    tick(1);
    I_TX_WE = 1'b0;
  endtask

  // The optional write lands on the same I_CLK edge as the start-of-frame load.
  task automatic frame_start(input bit wr, input logic [7:0] d);
    sif.SS_N_SLAVE = 1'b0;
    tick(2);
    if (wr) begin
      I_TX_WE = 1'b1;
      I_TX_DATA = d;
    end
    tick(1);
    I_TX_WE = 1'b0;
    tick(HALF - 3);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, input bit first);
    for (int i = 0; i < nbits; i++) begin
      if (!(first && i == 0)) sif.SCLK_SLAVE = 1'b0;
      sif.MOSI_SLAVE = w[7-i];
      tick(HALF);
      sif.SCLK_SLAVE = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic frame_end();
    sif.SS_N_SLAVE = 1'b1;
    sif.SCLK_SLAVE = 1'b0;
    sif.MOSI_SLAVE = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic snap();
    v0 = n_valid;
    u0 = n_under;
    f0 = n_ferr;
  endtask

  initial begin
    sif.SCLK_SLAVE = 1'b0;
    sif.SS_N_SLAVE = 1'b1;
    sif.MOSI_SLAVE = 1'b0;
    fork monitor(); join_none
    tick(3);
    chk("rst_miso", 32'(sif.MISO_SLAVE), 0);
    chk("rst_tx_ready", 32'(O_TX_READY), 1);
    chk("rst_rx_data", 32'(O_RX_DATA), 0);
    chk("rst_rx_valid", 32'(O_RX_VALID), 0);
    chk("rst_byte_cnt", 32'(O_BYTE_CNT), 0);
    chk("rst_busy", 32'(O_BUSY), 0);
    chk("rst_underrun", 32'(O_TX_UNDERRUN), 0);
    chk("rst_frame_err", 32'(O_FRAME_ERR), 0);
    I_RESETN = 1'b1;
    tick(5);

    // Single word with a preloaded TX word
    write_tx(8'hA5);
    chk("a_tx_ready_full", 32'(O_TX_READY), 0);
    snap();
    misoq.push_back(8'hA5); rxq.push_back(8'h3C); cntq.push_back(6'd1);
    frame_start(0, 8'h00);
    chk("a_busy", 32'(O_BUSY), 1);
    chk("a_tx_ready_loaded", 32'(O_TX_READY), 1);
    send_word(8'h3C, 8, 1);
    frame_end();
    chk("a_valid_pulses", 32'(n_valid - v0), 1);
    chk("a_underruns", 32'(n_under - u0), 0);
    chk("a_byte_cnt", 32'(O_BYTE_CNT), 1);
    chk("a_busy_idle", 32'(O_BUSY), 0);
    chk("a_miso_idle", 32'(sif.MISO_SLAVE), 0);

    // Two words with nothing to send
    snap();
    misoq.push_back(8'h00); misoq.push_back(8'h00);
    rxq.push_back(8'h4D); cntq.push_back(6'd1);
    rxq.push_back(8'h41); cntq.push_back(6'd2);
    frame_start(0, 8'h00);
    send_word(8'h4D, 8, 1);
    send_word(8'h41, 8, 0);
    frame_end();
    chk("b_underruns", 32'(n_under - u0), 2);
    chk("b_valid_pulses", 32'(n_valid - v0), 2);
    chk("b_rx_data_last", 32'(O_RX_DATA), 32'h41);

    // Abort after five bits, with a word written mid-frame
    snap();
    frame_start(0, 8'h00);
    write_tx(8'h5A);
    chk("c_tx_ready_full", 32'(O_TX_READY), 0);
    send_word(8'hFF, 5, 1);
    frame_end();
    chk("c_frame_err", 32'(n_ferr - f0), 1);
    chk("c_no_valid", 32'(n_valid - v0), 0);
    chk("c_underruns", 32'(n_under - u0), 1);
    chk("c_byte_cnt", 32'(O_BYTE_CNT), 0);
    chk("c_hold_kept", 32'(O_TX_READY), 0);
    chk("c_rx_data_kept", 32'(O_RX_DATA), 32'h41);
    snap();
    misoq.push_back(8'h5A); rxq.push_back(8'hC3); cntq.push_back(6'd1);
    frame_start(0, 8'h00);
    send_word(8'hC3, 8, 1);
    frame_end();
    chk("c2_valid_pulses", 32'(n_valid - v0), 1);
    chk("c2_frame_err", 32'(n_ferr - f0), 0);
    chk("c2_tx_ready", 32'(O_TX_READY), 1);

    // Second write while full is dropped
    snap();
    write_tx(8'h11);
    write_tx(8'h22);
    chk("d_tx_ready_full", 32'(O_TX_READY), 0);
    misoq.push_back(8'h11); misoq.push_back(8'h00);
    rxq.push_back(8'h96); cntq.push_back(6'd1);
    rxq.push_back(8'h0F); cntq.push_back(6'd2);
    frame_start(0, 8'h00);
    send_word(8'h96, 8, 1);
    send_word(8'h0F, 8, 0);
    frame_end();
    chk("d_underruns", 32'(n_under - u0), 1);
    chk("d_tx_ready", 32'(O_TX_READY), 1);

    // Write coinciding with an underrunning load goes to the next word
    snap();
    misoq.push_back(8'h00); misoq.push_back(8'h77);
    rxq.push_back(8'hE1); cntq.push_back(6'd1);
    rxq.push_back(8'h1E); cntq.push_back(6'd2);
    frame_start(1, 8'h77);
    chk("e_tx_ready_full", 32'(O_TX_READY), 0);
    send_word(8'hE1, 8, 1);
    send_word(8'h1E, 8, 0);
    frame_end();
    chk("e_underruns", 32'(n_under - u0), 1);
    chk("e_tx_ready", 32'(O_TX_READY), 1);

    // 65 words: byte counter wraps through zero back to one
    snap();
    frame_start(0, 8'h00);
    for (int i = 0; i < 65; i++) begin
      misoq.push_back(8'h00);
      rxq.push_back(8'(i * 7 + 3));
      cntq.push_back(6'((i + 1) % 64));
      send_word(8'(i * 7 + 3), 8, i == 0);
    end
    frame_end();
    chk("f_valid_pulses", 32'(n_valid - v0), 65);
    chk("f_underruns", 32'(n_under - u0), 65);
    chk("f_byte_cnt", 32'(O_BYTE_CNT), 1);

    // Reset mid-word with a full holding register
    misoq.push_back(8'h00); rxq.push_back(8'h5C); cntq.push_back(6'd1);
    frame_start(0, 8'h00);
    send_word(8'h5C, 8, 1);
    send_word(8'hAA, 3, 0);
    write_tx(8'h44);
    chk("g_tx_ready_full", 32'(O_TX_READY), 0);
    I_RESETN = 1'b0;
    #1;
    chk("g_rst_miso", 32'(sif.MISO_SLAVE), 0);
    chk("g_rst_tx_ready", 32'(O_TX_READY), 1);
    chk("g_rst_rx_data", 32'(O_RX_DATA), 0);
    chk("g_rst_rx_valid", 32'(O_RX_VALID), 0);
    chk("g_rst_byte_cnt", 32'(O_BYTE_CNT), 0);
    chk("g_rst_busy", 32'(O_BUSY), 0);
    chk("g_rst_underrun", 32'(O_TX_UNDERRUN), 0);
    chk("g_rst_frame_err", 32'(O_FRAME_ERR), 0);
    sif.SS_N_SLAVE = 1'b1;
    sif.SCLK_SLAVE = 1'b0;
    sif.MOSI_SLAVE = 1'b0;
    tick(4);
    snap();
    I_RESETN = 1'b1;
    tick(4 * HALF);
    chk("g_post_busy", 32'(O_BUSY), 0);
    chk("g_post_miso", 32'(sif.MISO_SLAVE), 0);
    chk("g_post_pulses", 32'((n_valid - v0) + (n_under - u0) + (n_ferr - f0)), 0);

    // SCLK activity with slave select high is ignored
    snap();
    sif.MOSI_SLAVE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sif.SCLK_SLAVE = 1'b1; tick(HALF);
      sif.SCLK_SLAVE = 1'b0; tick(HALF);
    end
    chk("h_idle_valid", 32'(n_valid - v0), 0);
    chk("h_idle_busy", 32'(O_BUSY), 0);
    chk("h_idle_miso", 32'(sif.MISO_SLAVE), 0);

    tick(4);
    chk("rx_queue_drained", 32'(rxq.size()), 0);
    chk("miso_queue_drained", 32'(misoq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
